// File: rtl/fruta_gen_if.sv
// Fruit spawner handshake and map read port bundle.
// master: the spawner (drives status/fruit/map address); slave: requester and map.
interface fruta_gen_if;
    logic       fruta_req;
    logic       fruta_busy;
    logic       fruta_valid;
    logic [9:0] fruta_x;
    logic [9:0] fruta_y;
    logic       fruta_fail;
    logic       map_renable;
    logic [9:0] map_rx;
    logic [9:0] map_ry;
    logic [1:0] map_rdata;

    modport master (
        input  fruta_req, map_rdata,
        output fruta_busy, fruta_valid, fruta_x, fruta_y, fruta_fail,
        output map_renable, map_rx, map_ry
    );

    modport slave (
        output fruta_req, map_rdata,
        input  fruta_busy, fruta_valid, fruta_x, fruta_y, fruta_fail,
        input  map_renable, map_rx, map_ry
    );
endinterface

// File: rtl/fruta_gen.sv
// Fruit spawner: random probing of the map, raster-scan fallback.
// Ports: clk, reset (sync, active-low), bus (fruta_gen_if.master).
module fruta_gen #(
    parameter int          MAPA_WIDTH  = 40,
    parameter int          MAPA_HEIGHT = 30,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          MAX_TRIES   = 64,
    parameter int          FRUTA_X0    = 13,
    parameter int          FRUTA_Y0    = 13
) (
    input  logic         clk,
    input  logic         reset,
    fruta_gen_if.master  bus
);
    localparam int XW = (MAPA_WIDTH  > 1) ? $clog2(MAPA_WIDTH)  : 1;
    localparam int YW = (MAPA_HEIGHT > 1) ? $clog2(MAPA_HEIGHT) : 1;

    localparam logic [9:0]  XMASK = 10'((1 << XW) - 1);
    localparam logic [9:0]  YMASK = 10'((1 << YW) - 1);
    localparam logic [10:0] W11   = 11'(MAPA_WIDTH);
    localparam logic [10:0] H11   = 11'(MAPA_HEIGHT);
    localparam logic [9:0]  XLAST = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0]  YLAST = 10'(MAPA_HEIGHT - 1);
    localparam logic [7:0]  TMAX  = 8'(MAX_TRIES);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0) ? 16'h0001 : SEED;
    localparam logic [15:0] MASK  = 16'hB400;

    typedef enum logic [2:0] {
        IDLE, PICK, READ, CHECK, SREAD, SCHECK, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [7:0]  tries_q, tries_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        fail_q, fail_d;
    logic        ren_q, ren_d;
    logic [9:0]  fx_q, fx_d;
    logic [9:0]  fy_q, fy_d;
    // The read address doubles as the current candidate cell.
    logic [9:0]  rx_q, rx_d;
    logic [9:0]  ry_q, ry_d;

    logic [9:0]  cx, cy;
    logic        in_range;

    // Field above bit 15 reads as zero for tall maps.
    assign cx = 10'(lfsr_q) & XMASK;
    assign cy = 10'(lfsr_q >> 8) & YMASK;
    assign in_range = ({1'b0, cx} < W11) && ({1'b0, cy} < H11);

    always_comb begin
        state_d = state_q;
        tries_d = tries_q;
        fx_d    = fx_q;
        fy_d    = fy_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        valid_d = 1'b0;
        fail_d  = 1'b0;
        lfsr_d  = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : 16'h0);

        unique case (state_q)
            IDLE: begin
                if (bus.fruta_req) begin
                    state_d = PICK;
                    tries_d = 8'd0;
                end
            end
            PICK: begin
                if (in_range) begin
                    rx_d    = cx;
                    ry_d    = cy;
                    state_d = READ;
                end
            end
            READ: state_d = CHECK;
            CHECK: begin
                if (bus.map_rdata == 2'b00) begin
                    fx_d    = rx_q;
                    fy_d    = ry_q;
                    state_d = DONE;
                end else begin
                    tries_d = tries_q + 8'd1;
                    if (tries_d == TMAX) begin
                        rx_d    = 10'd0;
                        ry_d    = 10'd0;
                        state_d = SREAD;
                    end else begin
                        state_d = PICK;
                    end
                end
            end
            SREAD: state_d = SCHECK;
            SCHECK: begin
                if (bus.map_rdata == 2'b00) begin
                    fx_d    = rx_q;
                    fy_d    = ry_q;
                    state_d = DONE;
                end else if (rx_q == XLAST && ry_q == YLAST) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (rx_q == XLAST) begin
                        rx_d = 10'd0;
                        ry_d = ry_q + 10'd1;
                    end else begin
                        rx_d = rx_q + 10'd1;
                    end
                    state_d = SREAD;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Strobe is high for the whole READ/SREAD cycle.
        ren_d  = (state_d == READ) || (state_d == SREAD);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            tries_q <= 8'd0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            ren_q   <= 1'b0;
            fx_q    <= 10'(FRUTA_X0);
            fy_q    <= 10'(FRUTA_Y0);
            rx_q    <= 10'd0;
            ry_q    <= 10'd0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            tries_q <= tries_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            ren_q   <= ren_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

    assign bus.fruta_busy  = busy_q;
    assign bus.fruta_valid = valid_q;
    assign bus.fruta_fail  = fail_q;
    assign bus.fruta_x     = fx_q;
    assign bus.fruta_y     = fy_q;
    assign bus.map_renable = ren_q;
    assign bus.map_rx      = rx_q;
    assign bus.map_ry      = ry_q;
endmodule

// File: tb/tb_fruta_gen.sv
// Bench for fruta_gen: randomized maps and request timing.
// Reference model predicts spawn cell, timing and read count.
module tb_fruta_gen;
    localparam int          W    = 40;
    localparam int          H    = 30;
    localparam int          MT   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fruta_gen_if bus();

    fruta_gen #(
        .MAPA_WIDTH(W), .MAPA_HEIGHT(H), .SEED(SEED),
        .MAX_TRIES(MT), .FRUTA_X0(13), .FRUTA_Y0(13)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [1:0] map [H][W];

    always @(posedge clk) begin
        if (bus.map_renable && int'(bus.map_ry) < H && int'(bus.map_rx) < W)
            bus.map_rdata <= map[int'(bus.map_ry)][int'(bus.map_rx)];
    end

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    logic [15:0] m_lfsr;
    always @(posedge clk) m_lfsr <= !reset ? SEED : step(m_lfsr);

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // kind 1 = spawn, 2 = fail; edge = cycles after request edge.
    task automatic predict(input logic [15:0] l0, output int kind,
                           output int pe, output int px, output int py,
                           output int reads);
        logic [15:0] l;
        int cyc, t, cx, cy;
        l = step(l0);
        cyc = 1; t = 0; reads = 0;
        kind = 0; pe = 0; px = 0; py = 0;
        for (int g = 0; g < 200000; g++) begin
            cx = int'(l) % 64;
            cy = (int'(l) / 256) % 32;
            if (cx >= W || cy >= H) begin
                l = step(l);
                cyc++;
            end else begin
                reads++;
                if (map[cy][cx] == 2'b00) begin
                    kind = 1; px = cx; py = cy; pe = cyc + 3;
                    return;
                end
                t++;
                if (t == MT) break;
                l = step(step(step(l)));
                cyc += 3;
            end
        end
        for (int i = 0; i < W * H; i++) begin
            reads++;
            if (map[i / W][i % W] == 2'b00) begin
                kind = 1; px = i % W; py = i / W; pe = cyc + 5 + 2 * i;
                return;
            end
        end
        kind = 2;
        pe = cyc + 4 + 2 * (W * H - 1);
    endtask

    task automatic spawn(input bit extra, input string tag);
        int kind, pe, px, py, pr;
        int nv, nf, ve, rd, both;
        logic [9:0] ox, oy;
        nv = 0; nf = 0; ve = -1; rd = 0; both = 0;
        ox = bus.fruta_x;
        oy = bus.fruta_y;
        bus.fruta_req = 1'b1;
        predict(m_lfsr, kind, pe, px, py, pr);
        @(posedge clk);
        @(negedge clk);
        bus.fruta_req = 1'b0;
        for (int k = 1; k <= pe + 4; k++) begin
            if (extra && k == 2) bus.fruta_req = 1'b1;
            if (k == 3) bus.fruta_req = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (bus.fruta_valid) begin nv++; ve = k; end
            if (bus.fruta_fail) nf++;
            if (bus.fruta_valid && bus.fruta_fail) both++;
            if (bus.map_renable) rd++;
        end
        if (kind == 1) begin
            chk({tag, " valid_cnt"}, nv, 1);
            chk({tag, " valid_cyc"}, ve, pe);
            chk({tag, " x"}, bus.fruta_x, px);
            chk({tag, " y"}, bus.fruta_y, py);
            chk({tag, " fail_cnt"}, nf, 0);
        end else begin
            chk({tag, " fail_cnt"}, nf, 1);
            chk({tag, " valid_cnt"}, nv, 0);
            chk({tag, " x_held"}, bus.fruta_x, ox);
            chk({tag, " y_held"}, bus.fruta_y, oy);
        end
        chk({tag, " both"}, both, 0);
        chk({tag, " reads"}, rd, pr);
        chk({tag, " busy"}, bus.fruta_busy, 0);
    endtask

    task automatic fill(input int pct_busy);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                map[y][x] = ($urandom_range(0, 99) < pct_busy)
                          ? 2'($urandom_range(1, 3)) : 2'b00;
    endtask

    initial begin
        int gap [20];
        int xa [20];
        int ya [20];
        bus.fruta_req = 1'b0;
        fill(0);
        for (int i = 0; i < 20; i++) gap[i] = $urandom_range(0, 5);

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst x", bus.fruta_x, 13);
        chk("rst y", bus.fruta_y, 13);
        chk("rst valid", bus.fruta_valid, 0);
        chk("rst fail", bus.fruta_fail, 0);
        chk("rst ren", bus.map_renable, 0);
        chk("rst busy", bus.fruta_busy, 0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            repeat (gap[i]) @(negedge clk);
            spawn(i % 5 == 0, "emptyA");
            xa[i] = int'(bus.fruta_x);
            ya[i] = int'(bus.fruta_y);
        end

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            repeat (gap[i]) @(negedge clk);
            spawn(i % 5 == 0, "emptyB");
            chk("det x", bus.fruta_x, xa[i]);
            chk("det y", bus.fruta_y, ya[i]);
        end

        for (int r = 0; r < 8; r++) begin
            fill(60 + 5 * r);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            spawn(r[0], "rndmap");
        end

        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) map[y][x] = 2'b01;
        map[H - 1][W - 1] = 2'b00;
        spawn(1'b0, "lastcell");
        chk("lastcell x", bus.fruta_x, W - 1);
        chk("lastcell y", bus.fruta_y, H - 1);

        map[H - 1][W - 1] = 2'b11;
        spawn(1'b1, "full");

        bus.fruta_req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.fruta_req = 1'b0;
        repeat (40) @(negedge clk);
        bus.fruta_req = 1'b1;
        @(negedge clk);
        bus.fruta_req = 1'b0;
        repeat (60) @(negedge clk);
        chk("midscan busy", bus.fruta_busy, 1);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk("midrst busy", bus.fruta_busy, 0);
        chk("midrst x", bus.fruta_x, 13);
        chk("midrst y", bus.fruta_y, 13);
        chk("midrst ren", bus.map_renable, 0);
        chk("midrst valid", bus.fruta_valid, 0);
        chk("midrst fail", bus.fruta_fail, 0);

        fill(30);
        spawn(1'b0, "afterrst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
